ysyx_25020037_icache: RTL

Direct-mapped instruction cache that sits beside the IFU. It receives a fetch address and request pulse from the IFU and returns a hit flag plus the instruction word. On a miss it asks the IFU to fetch the whole line over AXI. It then absorbs the returned line and answers from it. A flush input (fence.i) invalidates all lines.

---
 rtl/ysyx_25020037_icache_pkg.sv | 22 ++
 rtl/ysyx_25020037_icache_array.sv | 53 +++++
 rtl/ysyx_25020037_icache.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ysyx_25020037_icache_pkg.sv
// Shared definitions for the instruction cache.
// Contents: FSM state encoding and the address-split helpers used by the top.
package ysyx_25020037_icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    RESP   = 2'd3
  } icache_state_e;

  // Byte-offset width of a line.
  function automatic int off_w(input int block_size);
    return $clog2(block_size);
  endfunction

  // Index width.
  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

endpackage

// File: rtl/ysyx_25020037_icache_array.sv
// Valid/tag/line storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst        : clock, async active-high reset (clears valid bits only)
//   rd_idx_i        : read index; rd_valid_o/rd_tag_o/rd_line_o are combinational
//   wr_en_i         : write line at wr_idx_i with wr_tag_i/wr_line_i, set valid
//   clr_all_i       : clear every valid bit (wins over a write on the same edge)
module ysyx_25020037_icache_array #(
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 26,
  parameter int LINE_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i,
  input  logic              clr_all_i
);

  localparam int N = 1 << IDX_W;

  logic [N-1:0]      valid_q;
  logic [TAG_W-1:0]  tag_q  [N];
  logic [LINE_W-1:0] line_q [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data are deliberately left unreset; valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      line_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = line_q[rd_idx_i];

endmodule

// File: rtl/ysyx_25020037_icache.sv
// Direct-mapped instruction cache beside the IFU.
// Ports:
//   clk, rst                : clock, async active-high reset
//   icache_addr/icache_req  : lookup request (pulse) and fetch address
//   icache_data/icache_hit  : returned word and "resolved" flag (held in IDLE)
//   icache_ready            : idle, accepts a request or flush
//   mem_req/mem_addr        : line refill request and line-aligned address
//   mem_data/mem_ready      : refill line (byte 0 in [7:0]) and its valid
//   flush                   : invalidate all lines (fence.i)
//   hit_cnt/miss_cnt        : wrapping perf counters
module ysyx_25020037_icache
  import ysyx_25020037_icache_pkg::*;
#(
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             icache_addr,
  input  logic                    icache_req,
  output logic [31:0]             icache_data,
  output logic                    icache_hit,
  output logic                    icache_ready,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic [BLOCK_SIZE*8-1:0] mem_data,
  input  logic                    mem_ready,
  input  logic                    flush,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int OFF    = off_w(BLOCK_SIZE);
  localparam int IDX    = idx_w(NUM_LINES);
  localparam int TAG    = 32 - OFF - IDX;
  localparam int LINE_W = BLOCK_SIZE * 8;
  localparam int WORDS  = BLOCK_SIZE / 4;

  icache_state_e state_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic          hit_q;
  logic          mreq_q;
  logic [31:0]   maddr_q;
  logic [31:0]   hcnt_q;
  logic [31:0]   mcnt_q;
  logic          fpend_q;

  logic              rd_valid;
  logic [TAG-1:0]    rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              lookup_hit;
  logic              to_idle;
  logic              clr_all;
  logic              wr_en;

  // Word select is addr[OFF-1:2]; written as a mask so BLOCK_SIZE=4 needs no
  // zero-width slice.
  function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line,
                                           input logic [31:0]       addr);
    logic [31:0] w;
    w = (addr >> 2) & 32'(WORDS - 1);
    return line[w*32 +: 32];
  endfunction

  ysyx_25020037_icache_array #(
    .IDX_W  (IDX),
    .TAG_W  (TAG),
    .LINE_W (LINE_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (addr_q[OFF+IDX-1:OFF]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (wr_en),
    .wr_idx_i   (addr_q[OFF+IDX-1:OFF]),
    .wr_tag_i   (addr_q[31:OFF+IDX]),
    .wr_line_i  (mem_data),
    .clr_all_i  (clr_all)
  );

  assign lookup_hit = rd_valid && (rd_tag == addr_q[31:OFF+IDX]);
  assign to_idle    = ((state_q == LOOKUP) && lookup_hit) || (state_q == RESP);
  // A flush seen outside IDLE is deferred until the access returns to IDLE,
  // so the line just filled is also dropped.
  assign clr_all    = ((state_q == IDLE) && flush) || (to_idle && (flush || fpend_q));
  assign wr_en      = (state_q == FILL) && mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      hit_q   <= 1'b0;
      mreq_q  <= 1'b0;
      maddr_q <= '0;
      hcnt_q  <= '0;
      mcnt_q  <= '0;
      fpend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fpend_q <= 1'b0;
          if (icache_req) begin
            addr_q  <= icache_addr;
            hit_q   <= 1'b0;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookup_hit) begin
            hit_q   <= 1'b1;
            data_q  <= sel_word(rd_line, addr_q);
            hcnt_q  <= hcnt_q + 32'd1;
            fpend_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            mreq_q  <= 1'b1;
            maddr_q <= addr_q & ~32'(BLOCK_SIZE - 1);
            mcnt_q  <= mcnt_q + 32'd1;
            fpend_q <= fpend_q | flush;
            state_q <= FILL;
          end
        end
        FILL: begin
          fpend_q <= fpend_q | flush;
          if (mem_ready) begin
            mreq_q  <= 1'b0;
            data_q  <= sel_word(mem_data, addr_q);
            state_q <= RESP;
          end
        end
        RESP: begin
          hit_q   <= 1'b1;
          fpend_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign icache_data  = data_q;
  assign icache_hit   = hit_q;
  assign icache_ready = (state_q == IDLE);
  assign mem_req      = mreq_q;
  assign mem_addr     = maddr_q;
  assign hit_cnt      = hcnt_q;
  assign miss_cnt     = mcnt_q;

endmodule
